sr_flop_bank: RTL and testbench
===============================

# sr_flop_bank

Parametrised, clocked successor to the team's cross-coupled SR latch: a bank of `WIDTH` independent set/reset storage channels. Each channel is a synchronous register with optional input synchronisation and a selectable S&R conflict policy. Conflicting S&R requests are logged in per-channel sticky flags and a saturating counter, and `Qbar` is always the exact complement of `Q`. It sits wherever the design needs glitch-free, reset-defined status flags driven by asynchronous set/clear strobes: interrupt pending bits, error latches and handshake flags.

## Interface
- `WIDTH`, default 8: number of channels, 1..32.
- `MODE`, default 0: conflict policy when S=R=1 (active level).
  - 0: set-dominant.
  - 1: reset-dominant.
  - 2: hold.
  - 3: toggle (JK behaviour).
- `SYNC_STAGES`, default 2: synchroniser flops on S/R, 0..3; 0 = inputs already synchronous.
- `ACTIVE_LOW`, default 0: 1 = S/R asserted low, matching the legacy NAND-latch polarity.
- `INIT`, default 0: `WIDTH`-bit reset value of `Q`.
- `CNT_W`, default 8: conflict counter width, 2..16.

Ports (all outputs registered; clock and reset are fixed: one clock `clk`, asynchronous active-low reset `rst_n`):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `S`  in  WIDTH  per-channel set request.
- `R`  in  WIDTH  per-channel reset request.
- `en`  in  1  update enable; 0 = all channels hold, conflicts not logged.
- `clr_err`  in  1  one-cycle pulse; clears `err` and `conflict_cnt`.
- `Q`  out  WIDTH  channel state.
- `Qbar`  out  WIDTH  always `~Q`.
- `err`  out  WIDTH  sticky per-channel conflict flag.
- `conflict_cnt`  out  CNT_W  saturating count of cycles with at least one enabled conflict.

## Operation
- Polarity normalisation first: s = S ^ {WIDTH{ACTIVE_LOW}}, r likewise. Everything below uses the active-high s/r.
- s/r pass through `SYNC_STAGES` flops per bit, giving ss/rs. Synchroniser flops reset to inactive (0 after normalisation).
- Per channel, on each edge with `en`=1, next Q is:
  - ss=0, rs=0: hold.
  - ss=1, rs=0: Q=1.
  - ss=0, rs=1: Q=0.
  - ss=1, rs=1: per `MODE` (set, reset, hold, or invert).
- `en`=0: Q, `err` and `conflict_cnt` hold. Synchronisers keep shifting.
- Conflict logging uses the same ss/rs as the Q update.
  - conflict[i] = en & ss[i] & rs[i].
  - `err[i]` sets on conflict[i] and holds until cleared.
  - `conflict_cnt` increments by 1 when any conflict bit is 1, saturating at 2^CNT_W−1.
- `clr_err` together with new conflict(s) in the same cycle:
  - The new conflicts win: `err` = conflict vector, `conflict_cnt` = 1.
  - Otherwise `clr_err` gives `err`=0 and `conflict_cnt`=0.
- Legal parameter ranges are checked at elaboration; an out-of-range value is a fatal error.

## Timing
- Reset (asynchronous, immediate on `rst_n` falling):
  - Q=INIT, Qbar=~INIT, err=0, conflict_cnt=0, all synchroniser stages 0.
  - Held while `rst_n`=0.
- Release is synchronous to the next rising edge. The first update uses synchroniser contents, which are still 0, so Q holds INIT for `SYNC_STAGES` edges.
- Latency: an S/R change stable before edge k appears on Q, `err` and `conflict_cnt` after edge k+SYNC_STAGES. With SYNC_STAGES=0, that is after edge k.
- Pulse width: a request must be held at least one full clock period at the synchroniser input to be guaranteed captured. Shorter pulses may be missed, which is intended behaviour.
- Reset mid-operation aborts all in-flight synchroniser data. No request survives reset.
- `Qbar` is derived from the same register as `Q` (no separate flop). The S=R=1 invalid state of the legacy latch cannot occur.
- `clr_err` takes effect on the edge it is sampled high and is not synchronised; the caller drives it in the `clk` domain.

## Structure
- Package `sr_pkg`:
  - Mode constants `SR_SET_DOM`, `SR_RST_DOM`, `SR_HOLD`, `SR_TOGGLE`.
  - Limits `SR_MAX_WIDTH`=32 and `SR_MAX_SYNC`=3.
  - A function returning next Q from (q, s, r, mode), used by both RTL and the bench model.
- Sub-module `sr_sync`: parametrised per-bit flop chain (`STAGES`, `WIDTH`, asynchronous active-low reset, reset value 0). It is instantiated twice, once for S and once for R. A zero-stage chain is a wire.
- Top level holds the Q register, the conflict logic and the counter.

## Test plan
- **Reset value:** WIDTH=8, INIT=8'hA5, drive `rst_n`=0 mid-clock → Q=A5 and Qbar=5A immediately, err=0, conflict_cnt=0; after release with S=R=0, Q stays A5.
- **Latency:** SYNC_STAGES=2, pulse S=8'h01 for 1 cycle at edge k → Q[0]=1 after edge k+2, not before; R=8'h01 later → Q[0]=0 two edges after.
- **Mode sweep:** S=R=8'hFF for 3 cycles from Q=00 → MODE0: FF; MODE1: 00; MODE2: 00; MODE3: FF, 00, FF on successive cycles; err=FF, conflict_cnt=3 in every mode.
- **Saturation and clear:**
  - CNT_W=2 with 5 conflict cycles → count 1,2,3,3,3.
  - `clr_err` alone → err=0, cnt=0.
  - `clr_err` with a conflict on bit 4 → err=8'h10, cnt=1.
- **Enable and polarity:**
  - ACTIVE_LOW=1, S=8'hFE (bit 0 asserted) with en=0 → Q unchanged, no logging; then en=1 → Q[0]=1.
  - S=R=8'hFF (inactive) → hold.
- **Reset mid-flight:** SYNC_STAGES=3, assert S=8'h80, pull `rst_n` low one edge later, release → Q[7] stays INIT until S is re-asserted, then updates 3 edges later.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants and next-state function for the clocked set/reset flop bank.
// The next-state function is shared by the RTL and any reference model.
package sr_pkg;

    localparam int SR_SET_DOM   = 0;
    localparam int SR_RST_DOM   = 1;
    localparam int SR_HOLD      = 2;
    localparam int SR_TOGGLE    = 3;

    localparam int SR_MAX_WIDTH = 32;
    localparam int SR_MAX_SYNC  = 3;

    // s/r are active-high here; polarity is normalised before this is applied
    function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
        logic n;
        case ({s, r})
            2'b00:   n = q;
            2'b10:   n = 1'b1;
            2'b01:   n = 1'b0;
            default: begin
                case (mode)
                    SR_SET_DOM: n = 1'b1;
                    SR_RST_DOM: n = 1'b0;
                    SR_TOGGLE:  n = ~q;
                    default:    n = q;
                endcase
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sr_sync.sv
// Per-bit flop chain used to bring asynchronous set/reset strobes into clk.
// A zero-stage chain degenerates to a plain wire.
module sr_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (STAGES == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = clk ^ rst_n;
        assign o_q      = i_d;
    end else begin : g_chain
        logic [WIDTH-1:0] r_chain [STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < STAGES; k++) r_chain[k] <= '0;
            end else begin
                r_chain[0] <= i_d;
                for (int k = 1; k < STAGES; k++) r_chain[k] <= r_chain[k-1];
            end
        end

        assign o_q = r_chain[STAGES-1];
    end

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of clocked set/reset status flags with input synchronisation,
// selectable S&R conflict policy, sticky conflict flags and a saturating conflict count.
module sr_flop_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               MODE        = SR_SET_DOM,
    parameter int               SYNC_STAGES = 2,
    parameter int               ACTIVE_LOW  = 0,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (WIDTH < 1 || WIDTH > SR_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "sr_flop_bank: WIDTH out of range");
    end
    if (MODE < SR_SET_DOM || MODE > SR_TOGGLE) begin : g_bad_mode
        $fatal(1, "sr_flop_bank: MODE out of range");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > SR_MAX_SYNC) begin : g_bad_sync
        $fatal(1, "sr_flop_bank: SYNC_STAGES out of range");
    end
    if (ACTIVE_LOW < 0 || ACTIVE_LOW > 1) begin : g_bad_pol
        $fatal(1, "sr_flop_bank: ACTIVE_LOW out of range");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt
        $fatal(1, "sr_flop_bank: CNT_W out of range");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_s, w_r, w_ss, w_rs;
    logic [WIDTH-1:0] w_conflict, w_q_next;
    logic [WIDTH-1:0] r_q, r_err;
    logic [CNT_W-1:0] r_cnt;

    assign w_s = (ACTIVE_LOW != 0) ? ~S : S;
    assign w_r = (ACTIVE_LOW != 0) ? ~R : R;

    sr_sync #(.STAGES(SYNC_STAGES), .WIDTH(WIDTH)) u_sync_s (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_s),
        .o_q   (w_ss)
    );

    sr_sync #(.STAGES(SYNC_STAGES), .WIDTH(WIDTH)) u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_r),
        .o_q   (w_rs)
    );

    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            w_q_next[i] = sr_next(r_q[i], w_ss[i], w_rs[i], MODE);
        end
    end

    assign w_conflict = {WIDTH{en}} & w_ss & w_rs;

    // A clear coinciding with fresh conflicts restarts logging from those conflicts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= INIT;
            r_err <= '0;
            r_cnt <= '0;
        end else begin
            if (en) r_q <= w_q_next;
            if (clr_err) begin
                r_err <= w_conflict;
                r_cnt <= (|w_conflict) ? CNT_W'(1) : '0;
            end else begin
                r_err <= r_err | w_conflict;
                if ((|w_conflict) && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign Q            = r_q;
    assign Qbar         = ~r_q;
    assign err          = r_err;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: several parameterisations share one stimulus bus,
// each scenario task checks only the instance it targets.
module tb_sr_flop_bank;
    import sr_pkg::*;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] S       = 8'h00;
    logic [7:0] R       = 8'h00;
    logic       en      = 1'b1;
    logic       clr_err = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    logic [7:0] q_a, qb_a, err_a;   logic [7:0] cnt_a;
    logic [7:0] q_m0, qb_m0, err_m0; logic [7:0] cnt_m0;
    logic [7:0] q_m1, qb_m1, err_m1; logic [7:0] cnt_m1;
    logic [7:0] q_m2, qb_m2, err_m2; logic [7:0] cnt_m2;
    logic [7:0] q_m3, qb_m3, err_m3; logic [7:0] cnt_m3;
    logic [7:0] q_c2, qb_c2, err_c2; logic [1:0] cnt_c2;
    logic [7:0] q_al, qb_al, err_al; logic [7:0] cnt_al;
    logic [7:0] q_s3, qb_s3, err_s3; logic [7:0] cnt_s3;

    sr_flop_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(2), .ACTIVE_LOW(0), .INIT(8'hA5), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_a), .Qbar(qb_a), .err(err_a), .conflict_cnt(cnt_a));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(0), .ACTIVE_LOW(0), .INIT(8'h00), .CNT_W(8)) u_m0 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_m0), .Qbar(qb_m0), .err(err_m0), .conflict_cnt(cnt_m0));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_RST_DOM), .SYNC_STAGES(0), .ACTIVE_LOW(0), .INIT(8'h00), .CNT_W(8)) u_m1 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_m1), .Qbar(qb_m1), .err(err_m1), .conflict_cnt(cnt_m1));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_HOLD), .SYNC_STAGES(0), .ACTIVE_LOW(0), .INIT(8'h00), .CNT_W(8)) u_m2 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_m2), .Qbar(qb_m2), .err(err_m2), .conflict_cnt(cnt_m2));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_TOGGLE), .SYNC_STAGES(0), .ACTIVE_LOW(0), .INIT(8'h00), .CNT_W(8)) u_m3 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_m3), .Qbar(qb_m3), .err(err_m3), .conflict_cnt(cnt_m3));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(0), .ACTIVE_LOW(0), .INIT(8'h00), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_c2), .Qbar(qb_c2), .err(err_c2), .conflict_cnt(cnt_c2));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(0), .ACTIVE_LOW(1), .INIT(8'h00), .CNT_W(8)) u_al (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_al), .Qbar(qb_al), .err(err_al), .conflict_cnt(cnt_al));
    sr_flop_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(3), .ACTIVE_LOW(0), .INIT(8'h00), .CNT_W(8)) u_s3 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .en(en), .clr_err(clr_err),
        .Q(q_s3), .Qbar(qb_s3), .err(err_s3), .conflict_cnt(cnt_s3));

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] idle);
        rst_n = 1'b0; S = idle; R = idle; en = 1'b1; clr_err = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(8'h00);
        S = 8'hFF;
        repeat (4) step();
        vec_cnt++; if (q_a !== 8'hFF) begin err_cnt++; $display("FAIL reset_pre_set got %h want %h", q_a, 8'hFF); end
        @(posedge clk); #2; rst_n = 1'b0; #1;
        vec_cnt++; if (q_a !== 8'hA5) begin err_cnt++; $display("FAIL reset_q got %h want %h", q_a, 8'hA5); end
        vec_cnt++; if (qb_a !== 8'h5A) begin err_cnt++; $display("FAIL reset_qbar got %h want %h", qb_a, 8'h5A); end
        vec_cnt++; if (err_a !== 8'h00) begin err_cnt++; $display("FAIL reset_err got %h want %h", err_a, 8'h00); end
        vec_cnt++; if (cnt_a !== 8'h00) begin err_cnt++; $display("FAIL reset_cnt got %h want %h", cnt_a, 8'h00); end
        S = 8'h00;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++; if (q_a !== 8'hA5) begin err_cnt++; $display("FAIL reset_hold[%0d] got %h want %h", i, q_a, 8'hA5); end
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp_r [3];
        logic [7:0] exp_s [3];
        exp_r = '{8'hA5, 8'hA5, 8'hA4};
        exp_s = '{8'hA4, 8'hA4, 8'hA5};
        do_reset(8'h00);
        R = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step(); R = 8'h00;
            vec_cnt++; if (q_a !== exp_r[i]) begin err_cnt++; $display("FAIL latency_r[%0d] got %h want %h", i, q_a, exp_r[i]); end
        end
        vec_cnt++; if (qb_a !== 8'h5B) begin err_cnt++; $display("FAIL latency_qbar got %h want %h", qb_a, 8'h5B); end
        S = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step(); S = 8'h00;
            vec_cnt++; if (q_a !== exp_s[i]) begin err_cnt++; $display("FAIL latency_s[%0d] got %h want %h", i, q_a, exp_s[i]); end
        end
    endtask

    task automatic test_mode_sweep();
        logic [7:0] exp_t [3];
        exp_t = '{8'hFF, 8'h00, 8'hFF};
        do_reset(8'h00);
        S = 8'hFF; R = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            step();
            vec_cnt++; if (q_m0 !== 8'hFF) begin err_cnt++; $display("FAIL mode0_q[%0d] got %h want %h", c, q_m0, 8'hFF); end
            vec_cnt++; if (q_m1 !== 8'h00) begin err_cnt++; $display("FAIL mode1_q[%0d] got %h want %h", c, q_m1, 8'h00); end
            vec_cnt++; if (q_m2 !== 8'h00) begin err_cnt++; $display("FAIL mode2_q[%0d] got %h want %h", c, q_m2, 8'h00); end
            vec_cnt++; if (q_m3 !== exp_t[c]) begin err_cnt++; $display("FAIL mode3_q[%0d] got %h want %h", c, q_m3, exp_t[c]); end
            vec_cnt++; if (qb_m3 !== ~exp_t[c]) begin err_cnt++; $display("FAIL mode3_qbar[%0d] got %h want %h", c, qb_m3, ~exp_t[c]); end
            vec_cnt++; if (cnt_m3 !== 8'(c + 1)) begin err_cnt++; $display("FAIL mode3_cnt[%0d] got %0d want %0d", c, cnt_m3, c + 1); end
        end
        S = 8'h00; R = 8'h00;
        vec_cnt++; if ((err_m0 & err_m1 & err_m2 & err_m3) !== 8'hFF) begin err_cnt++;
            $display("FAIL mode_err got %h %h %h %h want ff", err_m0, err_m1, err_m2, err_m3); end
        vec_cnt++; if (cnt_m0 !== 8'd3 || cnt_m1 !== 8'd3 || cnt_m2 !== 8'd3) begin err_cnt++;
            $display("FAIL mode_cnt got %0d %0d %0d want 3", cnt_m0, cnt_m1, cnt_m2); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset(8'h00);
        S = 8'hFF; R = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step();
            vec_cnt++; if (cnt_c2 !== exp_c[c]) begin err_cnt++; $display("FAIL sat_cnt[%0d] got %0d want %0d", c, cnt_c2, exp_c[c]); end
        end
        S = 8'h00; R = 8'h00; clr_err = 1'b1;
        step(); clr_err = 1'b0;
        vec_cnt++; if (err_c2 !== 8'h00) begin err_cnt++; $display("FAIL clr_err got %h want %h", err_c2, 8'h00); end
        vec_cnt++; if (cnt_c2 !== 2'd0) begin err_cnt++; $display("FAIL clr_cnt got %0d want %0d", cnt_c2, 0); end
        S = 8'hFF; R = 8'hFF;
        step();
        vec_cnt++; if (err_c2 !== 8'hFF) begin err_cnt++; $display("FAIL pre_clr_err got %h want %h", err_c2, 8'hFF); end
        S = 8'h10; R = 8'h10; clr_err = 1'b1;
        step(); clr_err = 1'b0; S = 8'h00; R = 8'h00;
        vec_cnt++; if (err_c2 !== 8'h10) begin err_cnt++; $display("FAIL clr_new_err got %h want %h", err_c2, 8'h10); end
        vec_cnt++; if (cnt_c2 !== 2'd1) begin err_cnt++; $display("FAIL clr_new_cnt got %0d want %0d", cnt_c2, 1); end
    endtask

    task automatic test_enable_polarity();
        do_reset(8'hFF);
        step();
        vec_cnt++; if (q_al !== 8'h00) begin err_cnt++; $display("FAIL pol_idle got %h want %h", q_al, 8'h00); end
        en = 1'b0; S = 8'hFE;
        step(); step();
        vec_cnt++; if (q_al !== 8'h00) begin err_cnt++; $display("FAIL en0_q got %h want %h", q_al, 8'h00); end
        S = 8'h00; R = 8'h00;
        step();
        vec_cnt++; if (q_al !== 8'h00) begin err_cnt++; $display("FAIL en0_conf_q got %h want %h", q_al, 8'h00); end
        vec_cnt++; if (err_al !== 8'h00 || cnt_al !== 8'h00) begin err_cnt++;
            $display("FAIL en0_log got err %h cnt %0d want 00 0", err_al, cnt_al); end
        en = 1'b1; S = 8'hFE; R = 8'hFF;
        step();
        vec_cnt++; if (q_al !== 8'h01) begin err_cnt++; $display("FAIL en1_set got %h want %h", q_al, 8'h01); end
        S = 8'hFF;
        step();
        vec_cnt++; if (q_al !== 8'h01) begin err_cnt++; $display("FAIL pol_hold got %h want %h", q_al, 8'h01); end
        R = 8'hFE;
        step();
        vec_cnt++; if (q_al !== 8'h00) begin err_cnt++; $display("FAIL pol_rst got %h want %h", q_al, 8'h00); end
        R = 8'hFF;
    endtask

    task automatic test_reset_midflight();
        do_reset(8'h00);
        S = 8'h80;
        step();
        rst_n = 1'b0; S = 8'h00;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vec_cnt++; if (q_s3 !== 8'h00) begin err_cnt++; $display("FAIL abort_q[%0d] got %h want %h", i, q_s3, 8'h00); end
        end
        S = 8'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            vec_cnt++; if (q_s3 !== ((i == 3) ? 8'h80 : 8'h00)) begin err_cnt++;
                $display("FAIL resync_q[%0d] got %h want %h", i, q_s3, ((i == 3) ? 8'h80 : 8'h00)); end
        end
        S = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_mode_sweep();
        test_saturation();
        test_enable_polarity();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
